// File: rtl/rgmii_idelay_tap_ctrl.sv
// Loads and read-back-verifies IDELAYE2 tap values for the RGMII RX lanes.
// It waits for IDELAYCTRL ready, retries failed loads, and accepts runtime tap requests.
module rgmii_idelay_tap_ctrl #(
  parameter int num_lanes_p     = 5,
  parameter int tap_width_p     = 5,
  parameter int init_tap_p      = 0,
  parameter int settle_cycles_p = 4,
  parameter int max_retry_p     = 3
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               idelayctrl_rdy_i,
  input  logic                               tap_v_i,
  input  logic [tap_width_p-1:0]             tap_i,
  input  logic [num_lanes_p-1:0]             lane_mask_i,
  output logic                               tap_ready_o,
  output logic [num_lanes_p-1:0]             idelay_ld_o,
  output logic [tap_width_p-1:0]             idelay_cntvaluein_o,
  input  logic [num_lanes_p*tap_width_p-1:0] idelay_cntvalueout_i,
  output logic                               calibrated_o,
  output logic                               error_o,
  output logic [tap_width_p-1:0]             cur_tap_o
);

  localparam int settle_w_lp = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
  localparam int retry_w_lp  = (max_retry_p > 0) ? $clog2(max_retry_p + 1) : 1;

  localparam logic [settle_w_lp-1:0] settle_last_lp = settle_w_lp'(settle_cycles_p - 1);
  localparam logic [retry_w_lp-1:0]  retry_max_lp   = retry_w_lp'(max_retry_p);
  localparam logic [tap_width_p-1:0] init_tap_lp    = tap_width_p'(init_tap_p);

  typedef enum logic [2:0] {
    ST_WAIT_RDY,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_IDLE
  } state_e;

  state_e                   state;
  logic                     rdy_meta;
  logic                     rdy_s;
  logic [tap_width_p-1:0]   target;
  logic [num_lanes_p-1:0]   target_mask;
  logic [retry_w_lp-1:0]    retry;
  logic [settle_w_lp-1:0]   settle_cnt;
  logic                     mismatch;
  logic                     accept;

  // Two-flop synchronizer for the asynchronous IDELAYCTRL RDY.
  always_ff @(posedge clk_i) begin
    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample the pre-edge values and simulation matches the synthesized netlist.
    if (reset_i) begin
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      rdy_meta <= idelayctrl_rdy_i;
      rdy_s    <= rdy_meta;
    end
  end

  // Readback compare; only consumed by the CHECK state, so no output sees it combinationally.
  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves the
    // signal unassigned, which would otherwise infer a latch.
    mismatch = 1'b0;
    for (int i = 0; i < num_lanes_p; i++) begin
      if (target_mask[i] &&
          (idelay_cntvalueout_i[i*tap_width_p +: tap_width_p] != target)) begin
        mismatch = 1'b1;
      end
    end
  end

  assign tap_ready_o = (state == ST_IDLE) && rdy_s;
  assign accept      = tap_v_i && tap_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state               <= ST_WAIT_RDY;
      target              <= init_tap_lp;
      target_mask         <= '1;
      retry               <= '0;
      settle_cnt          <= '0;
      idelay_ld_o         <= '0;
      idelay_cntvaluein_o <= '0;
      calibrated_o        <= 1'b0;
      error_o             <= 1'b0;
      cur_tap_o           <= '0;
    end else if (!rdy_s && (state != ST_WAIT_RDY)) begin
      // Ready lost: abandon whatever is in flight and reload the target on recovery.
      state        <= ST_WAIT_RDY;
      target_mask  <= '1;
      retry        <= '0;
      idelay_ld_o  <= '0;
      calibrated_o <= 1'b0;
    end else begin
      idelay_ld_o <= '0;
      unique case (state)
        ST_WAIT_RDY: begin
          if (rdy_s) begin
            state               <= ST_LOAD;
            idelay_ld_o         <= target_mask;
            idelay_cntvaluein_o <= target;
          end
        end

        ST_LOAD: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end

        ST_SETTLE: begin
          if (settle_cnt == settle_last_lp) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        ST_CHECK: begin
          if (!mismatch) begin
            state        <= ST_IDLE;
            cur_tap_o    <= target;
            calibrated_o <= 1'b1;
            error_o      <= 1'b0;
            retry        <= '0;
          end else if (retry < retry_max_lp) begin
            state               <= ST_LOAD;
            retry               <= retry + 1'b1;
            idelay_ld_o         <= target_mask;
            idelay_cntvaluein_o <= target;
          end else begin
            state        <= ST_IDLE;
            error_o      <= 1'b1;
            calibrated_o <= 1'b0;
            retry        <= '0;
          end
        end

        ST_IDLE: begin
          // An empty lane mask completes the handshake without touching any lane.
          if (accept && (lane_mask_i != '0)) begin
            state               <= ST_LOAD;
            target              <= tap_i;
            target_mask         <= lane_mask_i;
            error_o             <= 1'b0;
            calibrated_o        <= 1'b0;
            idelay_ld_o         <= lane_mask_i;
            idelay_cntvaluein_o <= tap_i;
          end
        end

        default: state <= ST_WAIT_RDY;
      endcase
    end
  end

endmodule
